// File: rtl/sbox_pkg.sv
// AES byte-substitution tables (FIPS-197 forward and inverse S-box),
// shared by the lane pipeline and key expansion.
package sbox_pkg;

   localparam int LANE_W = 8;

   localparam logic [7:0] SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [LANE_W-1:0] sbox_fwd(input logic [LANE_W-1:0] b);
      return SBOX_FWD[b];
   endfunction

   function automatic logic [LANE_W-1:0] sbox_inv(input logic [LANE_W-1:0] b);
      return SBOX_INV[b];
   endfunction

endpackage

// File: rtl/sbox_lane_pipeline_if.sv
// Beat-level handshake bundle for the S-box lane pipeline: upstream beat
// with its mode tag, downstream result with the tag that travelled along.
interface sbox_lane_pipeline_if #(
   parameter int LANES = 4
) ();
   logic                                in_valid;
   logic                                in_ready;
   logic                                dec;
   logic [sbox_pkg::LANE_W*LANES-1:0]   data_in;
   logic                                out_valid;
   logic                                out_ready;
   logic [sbox_pkg::LANE_W*LANES-1:0]   data_out;
   logic                                out_dec;

   modport master (
      output in_valid, dec, data_in, out_ready,
      input  in_ready, out_valid, data_out, out_dec
   );

   modport slave (
      input  in_valid, dec, data_in, out_ready,
      output in_ready, out_valid, data_out, out_dec
   );
endinterface

// File: rtl/sbox_lut.sv
// Single-lane combinational substitution: forward or inverse S-box
// selected by the mode bit that travelled with the beat.
module sbox_lut
   import sbox_pkg::*;
(
   input  logic [LANE_W-1:0] lane_byte,
   input  logic              dec,
   output logic [LANE_W-1:0] sub_byte
);

   // table select for one byte
   always_comb begin
      if (dec) begin
         sub_byte = sbox_inv(lane_byte);
      end else begin
         sub_byte = sbox_fwd(lane_byte);
      end
   end

endmodule

// File: rtl/sbox_lane_pipeline.sv
// Two-stage elastic S-box pipeline: input register, per-lane lookup,
// output register, with a wrapping count of delivered beats.
module sbox_lane_pipeline
   import sbox_pkg::*;
#(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   sbox_lane_pipeline_if.slave  bus,
   output logic [CNT_W-1:0]     done_count
);

   localparam int DATA_W = LANES * LANE_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              s0_valid_r;
   logic              s0_dec_r;
   logic [DATA_W-1:0] s0_data_r;
   logic              s1_valid_r;
   logic              s1_dec_r;
   logic [DATA_W-1:0] s1_data_r;
   logic [DATA_W-1:0] lut_s;
   logic [CNT_W-1:0]  count_r;
   logic              s0_ready_s;
   logic              s1_ready_s;

   // a stage may take new data when empty or when its contents leave this cycle
   always_comb begin
      s1_ready_s = ~s1_valid_r | bus.out_ready;
      s0_ready_s = ~s0_valid_r | s1_ready_s;
   end

   assign bus.in_ready  = s0_ready_s & ~rst;
   assign bus.out_valid = s1_valid_r;
   assign bus.data_out  = s1_data_r;
   assign bus.out_dec   = s1_dec_r;
   assign done_count    = count_r;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      sbox_lut u_lut (
         .lane_byte (s0_data_r[k*LANE_W +: LANE_W]),
         .dec       (s0_dec_r),
         .sub_byte  (lut_s[k*LANE_W +: LANE_W])
      );
   end

   // stage 0: capture the upstream beat together with its mode
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid_r <= 1'b0;
         s0_dec_r   <= 1'b0;
         s0_data_r  <= {DATA_W{1'b0}};
      end else if (s0_ready_s) begin
         s0_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            s0_data_r <= bus.data_in;
            s0_dec_r  <= bus.dec;
         end
      end
   end

   // stage 1: register the looked-up bytes; contents hold while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_dec_r   <= 1'b0;
         s1_data_r  <= {DATA_W{1'b0}};
      end else if (s1_ready_s) begin
         s1_valid_r <= s0_valid_r;
         if (s0_valid_r) begin
            s1_data_r <= lut_s;
            s1_dec_r  <= s0_dec_r;
         end
      end
   end

   // delivered-beat counter, wraps silently
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (s1_valid_r & bus.out_ready) begin
         count_r <= count_r + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_sbox_lane_pipeline.sv
// Scoreboard bench: drivers push expected beats, negedge monitors pop and
// compare on every delivered beat; reference S-box is derived from GF(2^8).
module tb_sbox_lane_pipeline;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0]  cnt4;
   logic [15:0] cnt1;
   logic [3:0]  exp_cnt4 = 4'd0;
   logic [15:0] exp_cnt1 = 16'd0;
   logic mon_on = 1'b0;
   logic rand_on = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [32:0] q4[$];
   logic [8:0]  q1[$];
   logic [7:0] fwd_ref [256];
   logic [7:0] inv_ref [256];

   always #5 clk = ~clk;

   sbox_lane_pipeline_if #(.LANES(4)) bus4 ();
   sbox_lane_pipeline_if #(.LANES(1)) bus1 ();

   sbox_lane_pipeline #(.LANES(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .bus(bus4), .done_count(cnt4));
   sbox_lane_pipeline #(.LANES(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .done_count(cnt1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] affine_of_inverse(input logic [7:0] a);
      logic [7:0] b;
      logic [7:0] r;
      logic [7:0] s;
      b = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(a, 8'(c)) == 8'h01) b = 8'(c);
      r = b; s = b;
      for (int n = 0; n < 4; n++) begin
         r = {r[6:0], r[7]};
         s = s ^ r;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [31:0] ref4(input logic [31:0] d, input logic m);
      logic [31:0] r;
      for (int k = 0; k < 4; k++)
         r[8*k +: 8] = m ? inv_ref[d[8*k +: 8]] : fwd_ref[d[8*k +: 8]];
      return r;
   endfunction

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic send4(input logic [31:0] d, input logic m, input logic [31:0] e);
      int n;
      bus4.in_valid = 1'b1; bus4.data_in = d; bus4.dec = m;
      n = 0;
      @(negedge clk);
      while (!bus4.in_ready && n < 100) begin n++; @(negedge clk); end
      if (bus4.in_ready) q4.push_back({m, e});
      else check("accept4_timeout", 32'(bus4.in_ready), 32'd1);
      sync();
      bus4.in_valid = 1'b0; bus4.dec = ~m; bus4.data_in = ~d;
   endtask

   task automatic send1(input logic [7:0] d, input logic m, input logic [7:0] e);
      int n;
      bus1.in_valid = 1'b1; bus1.data_in = d; bus1.dec = m;
      n = 0;
      @(negedge clk);
      while (!bus1.in_ready && n < 100) begin n++; @(negedge clk); end
      if (bus1.in_ready) q1.push_back({m, e});
      else check("accept1_timeout", 32'(bus1.in_ready), 32'd1);
      sync();
      bus1.in_valid = 1'b0; bus1.dec = ~m; bus1.data_in = ~d;
   endtask

   // lane-4 monitor: counter tracking and in-order result comparison
   always @(negedge clk) begin
      logic [32:0] e;
      if (mon_on) begin
         check("count4", 32'(cnt4), 32'(exp_cnt4));
         if (rst) begin
            q4.delete();
            exp_cnt4 = 4'd0;
         end else if (bus4.out_valid && bus4.out_ready) begin
            if (q4.size() == 0) begin
               check("unexpected_beat4", bus4.data_out, 32'hxxxxxxxx);
            end else begin
               e = q4.pop_front();
               check("data4", bus4.data_out, e[31:0]);
               check("dec4", 32'(bus4.out_dec), 32'(e[32]));
            end
            exp_cnt4 = exp_cnt4 + 4'd1;
         end
      end
   end

   // lane-1 monitor for the exhaustive sweep
   always @(negedge clk) begin
      logic [8:0] e;
      if (mon_on) begin
         check("count1", 32'(cnt1), 32'(exp_cnt1));
         if (rst) begin
            q1.delete();
            exp_cnt1 = 16'd0;
         end else if (bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
               check("unexpected_beat1", 32'(bus1.data_out), 32'hxxxxxxxx);
            end else begin
               e = q1.pop_front();
               check("data1", 32'(bus1.data_out), 32'(e[7:0]));
               check("dec1", 32'(bus1.out_dec), 32'(e[8]));
            end
            exp_cnt1 = exp_cnt1 + 16'd1;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_on) bus1.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [31:0] d;
      bus4.in_valid = 1'b0; bus4.dec = 1'b0; bus4.data_in = 32'h0; bus4.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.dec = 1'b0; bus1.data_in = 8'h0; bus1.out_ready = 1'b1;
      for (int x = 0; x < 256; x++) fwd_ref[x] = affine_of_inverse(8'(x));
      for (int x = 0; x < 256; x++) inv_ref[fwd_ref[x]] = 8'(x);

      // reset state
      rst = 1'b1;
      sync();
      mon_on = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(bus4.in_ready), 32'd0);
      sync();
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
      check("rst_data_out", bus4.data_out, 32'h0);
      check("rst_out_dec", 32'(bus4.out_dec), 32'd0);
      check("rst_in_ready_after", 32'(bus4.in_ready), 32'd1);
      sync();

      // 1: forward lookup and latency
      send4(32'hC853_0100, 1'b0, 32'hE8ED_7C63);
      @(negedge clk); check("lat1_early", 32'(bus4.out_valid), 32'd0);
      @(negedge clk); check("lat1_valid", 32'(bus4.out_valid), 32'd1);
      @(negedge clk); check("t1_count", 32'(cnt4), 32'd1);
      sync();

      // 2: inverse then forward back-to-back
      send4(32'h00ED_7C63, 1'b1, 32'h5253_0100);
      send4(32'h0000_00FF, 1'b0, 32'h6363_6316);
      @(negedge clk);
      check("t2_valid_a", 32'(bus4.out_valid), 32'd1);
      check("t2_dec_a", 32'(bus4.out_dec), 32'd1);
      @(negedge clk);
      check("t2_valid_b", 32'(bus4.out_valid), 32'd1);
      check("t2_dec_b", 32'(bus4.out_dec), 32'd0);
      sync(); sync();

      // 3: backpressure holds two beats, output stable
      bus4.out_ready = 1'b0;
      send4(32'h0001_0203, 1'b0, 32'h637C_777B);
      send4(32'h1020_3040, 1'b0, 32'hCAB7_0409);
      bus4.in_valid = 1'b1; bus4.data_in = 32'h5060_7080; bus4.dec = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_in_ready_low", 32'(bus4.in_ready), 32'd0);
         check("t3_out_valid", 32'(bus4.out_valid), 32'd1);
         check("t3_hold_a", bus4.data_out, 32'h637C_777B);
      end
      sync();
      bus4.out_ready = 1'b1;
      send4(32'h5060_7080, 1'b0, 32'h53D0_51CD);
      repeat (4) @(negedge clk);
      check("t3_count", 32'(cnt4), 32'd6);
      sync();

      // 4: reset with two beats in flight
      bus4.out_ready = 1'b0;
      send4(32'h1122_3344, 1'b0, 32'h8293_C31B);
      send4(32'h5566_7788, 1'b0, 32'hFC33_F5C4);
      rst = 1'b1;
      @(negedge clk);
      check("t4_in_ready_rst", 32'(bus4.in_ready), 32'd0);
      sync();
      rst = 1'b0;
      bus4.out_ready = 1'b1;
      @(negedge clk);
      check("t4_out_valid", 32'(bus4.out_valid), 32'd0);
      check("t4_data_out", bus4.data_out, 32'h0);
      check("t4_count", 32'(cnt4), 32'd0);
      check("t4_in_ready", 32'(bus4.in_ready), 32'd1);
      sync();
      send4(32'hFFFF_FFFF, 1'b0, 32'h1616_1616);
      @(negedge clk); check("lat4_early", 32'(bus4.out_valid), 32'd0);
      @(negedge clk); check("lat4_valid", 32'(bus4.out_valid), 32'd1);
      sync(); sync();

      // 5: counter wrap on a 4-bit count
      rst = 1'b1;
      sync();
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         d = {8'(i), 8'(i + 64), 8'(i + 128), 8'(i + 192)};
         send4(d, 1'(i), ref4(d, 1'(i)));
      end
      repeat (4) @(negedge clk);
      check("t5_wrap_count", 32'(cnt4), 32'd1);
      sync();

      // 6: exhaustive single-lane sweep with random downstream stalls
      rand_on = 1'b1;
      for (int x = 0; x < 256; x++) send1(8'(x), 1'b0, fwd_ref[x]);
      for (int x = 0; x < 256; x++) send1(fwd_ref[x], 1'b1, 8'(x));
      rand_on = 1'b0;
      @(posedge clk); #2;
      bus1.out_ready = 1'b1;

      n = 0;
      while ((q4.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(q4.size() + q1.size()), 32'd0);
      @(negedge clk);
      check("t6_count", 32'(cnt1), 32'd512);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sbox_lane_pipeline.md
Name: sbox_lane_pipeline

Overview:
- Multi-lane AES S-box converter: LANES independent bytes per beat, each substituted through the forward S-box (encrypt) or inverse S-box (decrypt).
- The mode is carried per beat, so encrypt and decrypt beats can interleave back-to-back.
- Two-stage elastic pipeline with valid/ready handshakes on both sides, plus a completed-beat counter.
- Sits between the round-key/state datapath and the byte-substitution consumers, replacing the single-byte, non-handshaked converter.

Parameters:
- LANES, 4, number of byte lanes per beat (1..16; 4 = SubWord, 16 = full SubBytes).
- CNT_W, 16, width of the completed-beat counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- dec  in  1  mode for this beat: 0 = forward S-box, 1 = inverse S-box; sampled with the beat.
- data_in  in  8*LANES  lane k = bits [8k+7:8k].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- data_out  out  8*LANES  substituted bytes, lane-aligned with data_in.
- out_dec  out  1  mode tag that travelled with the beat.
- done_count  out  CNT_W  number of beats delivered (out_valid & out_ready), wraps.

Behaviour:
- Reset (rst high at a clock edge):
  - s0_valid, s1_valid, out_valid = 0; data_out = 0; out_dec = 0; done_count = 0.
  - in_ready = 0 while rst is high.
  - Stage contents are discarded, including any beat in flight mid-operation.
  - First acceptance is possible on the cycle after rst falls.
- Stage 0 (input register):
  - On in_valid & in_ready, capture data_in and dec; set s0_valid.
- Stage 1 (output register):
  - Captures the per-lane lookup of stage-0 data, selected by the stage-0 dec bit.
  - Drives out_valid = s1_valid, data_out, out_dec directly from flops; no combinational path from data_in to data_out.
- Advance rules:
  - s1_ready = ~s1_valid | out_ready.
  - s0_ready = ~s0_valid | s1_ready.
  - in_ready = s0_ready & ~rst.
  - Stage 1 loads when s0_valid & s1_ready. Stage 1 clears when it is emptied by out_ready and not reloaded.
  - Stage 0 loads/clears symmetrically against s1_ready.
  - Simultaneous drain and fill of a stage in one cycle is allowed, giving 1 beat/cycle sustained throughput.
- Latency:
  - A beat accepted at edge N appears with out_valid at edge N+2 when unstalled.
- Backpressure:
  - With out_ready low, at most 2 beats are held.
  - in_ready drops once both stages are full.
  - data_out and out_dec stay stable while out_valid & ~out_ready.
  - Ordering is strictly FIFO.
- Mode:
  - Lookup uses the dec captured with each beat, never the current dec input.
  - Mixed-mode beats in the pipe are correct.
- Lookup:
  - Standard AES S-box / inverse S-box (FIPS-197), applied independently per lane.
  - No cross-lane dependence.
- done_count:
  - +1 on each out_valid & out_ready cycle.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Illegal input:
  - in_valid while in_ready is low: the beat is not taken and no state changes.
  - Upstream must hold the beat.

Decomposition:
- sbox_pkg:
  - LANE_W = 8.
  - Functions/constant ROMs sbox_fwd(byte) and sbox_inv(byte), 256 entries each.
  - Shared by this block and key expansion.
- Sub-module sbox_lut:
  - Combinational, 8-bit in, dec in, 8-bit out.
  - Instantiated LANES times in a generate loop between stage 0 and stage 1.

Test Plan:
1. Basic forward lookup, LANES=4, out_ready=1:
   - Stimulus: dec=0, data_in=32'hC8_53_01_00 for one cycle.
   - Required: two edges later out_valid=1, data_out=32'hE8_ED_7C_63, out_dec=0, done_count=1.
2. Inverse lookup and interleave:
   - Stimulus: dec=1, 32'h00_ED_7C_63, then immediately dec=0, 32'h00_00_00_FF.
   - Required: consecutive outputs 32'h52_53_01_00 (out_dec=1), then 32'h63_63_63_16 (out_dec=0); one beat per cycle.
3. Backpressure:
   - Stimulus: out_ready=0, offer beats A, B, C (forward).
   - Required: A and B are accepted; in_ready=0 while C is offered; data_out holds A stable.
   - Then raise out_ready: outputs A, B, C in order with correct lookups; done_count=3.
4. Reset mid-operation:
   - Stimulus: two beats in flight, then pulse rst for one cycle.
   - Required: out_valid=0, data_out=0, done_count=0 on the next edge; neither beat is ever output.
   - A new beat after reset returns at +2 edges.
5. Counter wrap, CNT_W=4:
   - Stimulus: stream 17 beats.
   - Required: done_count = 1 after the final beat (wrapped via 15 -> 0).
6. Exhaustive sweep, LANES=1:
   - Stimulus: all 256 inputs in both modes, continuous streaming with random out_ready.
   - Required: every output matches the sbox_pkg reference; inv(fwd(x)) = x.
